// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB full-speed receive path.
package usb_rx_pkg;

    typedef enum logic [3:0] {
        IDLE,
        SYNC,
        SYNC_CHK,
        RECV,
        BYTE_CHK,
        EOP_HOLD,
        EOP_END,
        DONE,
        ERR_WAIT,
        ERR_EOP
    } rx_ctrl_state_t;

    localparam logic [7:0] USB_SYNC_BYTE = 8'h80;

endpackage

// File: rtl/rx_bit_counter.sv
// Counts sampled bits within a byte; byte_done flags the sample that completes a byte.
module rx_bit_counter (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       clear,
    input  logic       enable,
    output logic [2:0] count,
    output logic       byte_done
);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count <= 3'd0;
        end else if (clear) begin
            count <= 3'd0;
        end else if (enable) begin
            count <= count + 3'd1;
        end
    end

    assign byte_done = enable && (count == 3'd7);

endmodule

// File: rtl/rx_packet_ctrl.sv
// Receive packet sequencer: sync check, byte framing, FIFO write strobes, EOP validation.
module rx_packet_ctrl
    import usb_rx_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = USB_SYNC_BYTE,
    parameter int         MAX_BYTES = 64,
    parameter int         CNT_W     = $clog2(MAX_BYTES + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             d_edge,
    input  logic             eop,
    input  logic             shift_en,
    input  logic [7:0]       rcv_data,
    output logic             rcving,
    output logic             w_enable,
    output logic             r_error,
    output logic             pkt_done,
    output logic [CNT_W-1:0] pkt_bytes
);

    rx_ctrl_state_t state, next_state;

    logic [2:0] bit_cnt;
    logic       byte_done;
    logic       bit_en;
    logic       eop_bit;
    logic       pkt_start;
    logic       pkt_full;

    assign eop_bit   = shift_en && eop;
    assign bit_en    = shift_en && !eop && ((state == SYNC) || (state == RECV));
    assign pkt_start = (state == IDLE) && d_edge;
    assign pkt_full  = (pkt_bytes >= CNT_W'(MAX_BYTES));

    rx_bit_counter u_bit_counter (
        .clk       (clk),
        .n_rst     (n_rst),
        .clear     (pkt_start),
        .enable    (bit_en),
        .count     (bit_cnt),
        .byte_done (byte_done)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // SE0 on a bit sample always wins over a completing byte.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (d_edge) next_state = SYNC;
            SYNC: begin
                if (eop_bit)        next_state = ERR_EOP;
                else if (byte_done) next_state = SYNC_CHK;
            end
            SYNC_CHK: next_state = (rcv_data == SYNC_BYTE) ? RECV : ERR_WAIT;
            RECV: begin
                if (eop_bit) begin
                    if ((bit_cnt == 3'd0) && (pkt_bytes != '0)) next_state = EOP_HOLD;
                    else                                         next_state = ERR_EOP;
                end else if (byte_done) begin
                    next_state = BYTE_CHK;
                end
            end
            BYTE_CHK: next_state = pkt_full ? ERR_WAIT : RECV;
            EOP_HOLD: if (shift_en) next_state = eop ? EOP_END : ERR_WAIT;
            EOP_END:  if (d_edge) next_state = DONE;
            DONE:     next_state = IDLE;
            ERR_WAIT: if (eop_bit) next_state = ERR_EOP;
            ERR_EOP:  if (d_edge) next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    always_comb begin
        rcving   = (state != IDLE);
        w_enable = (state == BYTE_CHK) && !pkt_full;
        pkt_done = (state == DONE);
    end

    // Error flag survives until the next packet starts, so the protocol layer can read it late.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_error <= 1'b0;
        end else if (pkt_start) begin
            r_error <= 1'b0;
        end else if ((next_state == ERR_WAIT) || (next_state == ERR_EOP)) begin
            r_error <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pkt_bytes <= '0;
        end else if (pkt_start) begin
            pkt_bytes <= '0;
        end else if ((state == BYTE_CHK) && !pkt_full) begin
            pkt_bytes <= pkt_bytes + CNT_W'(1);
        end
    end

endmodule

// File: doc/rx_packet_ctrl.md
Name: rx_packet_ctrl

Overview:
Receive-side packet sequencer for the USB full-speed RX path.
- Consumes the SE0/EOP flag, the edge-detect pulse, the bit-rate shift_en strobe and the parallel byte from the RX shift register.
- Frames each packet: sync check, byte counting, FIFO write strobes, EOP validation.
- Sits between the RX bit-level blocks (edge detect, decoder, EOP detect, shift register) and the RX FIFO / protocol layer.

Parameters:
- SYNC_BYTE, 8'h80, value rcv_data must hold after the first 8 bits of a packet.
- MAX_BYTES, 64, maximum number of payload bytes written per packet; one more is an overflow.
- CNT_W, $clog2(MAX_BYTES+1), width of pkt_bytes.

Ports:
- clk  input  1  system clock.
- n_rst  input  1  asynchronous active-low reset.
- d_edge  input  1  one-cycle pulse on any D+ transition.
- eop  input  1  line is SE0 (D+ = D- = 0), synchronised.
- shift_en  input  1  one-cycle bit-sample strobe; shift register updates on the same edge.
- rcv_data  input  8  parallel output of the RX shift register.
- rcving  output  1  packet reception in progress.
- w_enable  output  1  one-cycle FIFO write strobe for rcv_data.
- r_error  output  1  sticky receive-error flag.
- pkt_done  output  1  one-cycle pulse on clean packet end.
- pkt_bytes  output  CNT_W  payload bytes written in current/last packet.

Behaviour:
Reset (async, n_rst=0):
- state=IDLE; bit_cnt=0; pkt_bytes=0; rcving=0, w_enable=0, r_error=0, pkt_done=0.
- Reset mid-packet abandons the packet with no pulse.

Bit counter:
- 3-bit; counts shift_en in SYNC and RECV when eop=0.
- byte_done = shift_en & eop=0 & bit_cnt==7; counter wraps to 0.
- Cleared on entry to SYNC.

Priority: shift_en & eop is evaluated before byte_done.

States (outputs Moore, registered from state):
- IDLE: rcving=0. On d_edge → SYNC; clear r_error, pkt_bytes=0.
- SYNC: on shift_en&eop → ERR_EOP, set r_error. On byte_done → SYNC_CHK.
- SYNC_CHK (1 cycle): samples rcv_data. If equal to SYNC_BYTE → RECV, else → ERR_WAIT, set r_error.
- RECV: on shift_en&eop:
  - if bit_cnt==0 and pkt_bytes≥1 → EOP_HOLD;
  - else → ERR_EOP, set r_error (mid-byte or empty packet).
  - On byte_done → BYTE_CHK.
- BYTE_CHK (1 cycle):
  - if pkt_bytes<MAX_BYTES: w_enable=1, pkt_bytes+1, → RECV;
  - else: w_enable=0, set r_error, → ERR_WAIT (overflow).
- EOP_HOLD: on shift_en, eop=1 → EOP_END; eop=0 → ERR_WAIT, set r_error (SE0 only 1 bit).
- EOP_END: on d_edge (return to J) → DONE.
- DONE (1 cycle): pkt_done=1 → IDLE.
- ERR_WAIT: on shift_en&eop → ERR_EOP.
- ERR_EOP: on d_edge → IDLE; r_error stays 1.

Output and flag rules:
- rcving=1 in every state except IDLE.
- r_error is sticky; cleared only on IDLE→SYNC transition.
- pkt_done never asserts in a packet where r_error was set.
- Latency: w_enable asserts exactly 1 clk after the shift_en completing the byte, while rcv_data is stable.
- pkt_done asserts 1 clk after the d_edge ending EOP.

Decomposition:
- Package usb_rx_pkg: state enum rx_ctrl_state_t (IDLE, SYNC, SYNC_CHK, RECV, BYTE_CHK, EOP_HOLD, EOP_END, DONE, ERR_WAIT, ERR_EOP), constant USB_SYNC_BYTE = 8'h80.
- Sub-module rx_bit_counter: 3-bit counter with clear, enable, byte_done rollover flag; instantiated once.

Test Plan:
1. Edge, 8 shifts giving rcv_data=8'h80, 2 bytes (8'hC3, 8'hA5), 2 SE0 bits, edge → two w_enable pulses one clk after each 8th shift_en; pkt_done=1 one clk after final edge; pkt_bytes=2; r_error=0.
2. Sync byte 8'h81 → r_error=1 one clk after SYNC_CHK; no w_enable. SE0 + edge → IDLE with r_error=1. Next edge → r_error=0.
3. SE0 after 3 bits of second byte → r_error=1, no pkt_done, pkt_bytes=1, rcving falls after trailing edge.
4. Single-bit SE0 then J sample → r_error=1, state ERR_WAIT until next SE0 sample; no pkt_done.
5. MAX_BYTES=4, send 5 bytes → exactly 4 w_enable pulses, r_error=1 at fifth BYTE_CHK, pkt_bytes=4.
6. n_rst low during RECV at bit 5 → all outputs 0 same cycle. After release, a full valid packet completes normally with pkt_bytes counting from 0.
